alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 87 ++++++++
 tb/tb_alu_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two requesters, the shared ALU and the
// response consumer of alu_arbiter.
interface alu_arbiter_if #(
  parameter int DW = 4
);
  logic          req0_valid;
  logic          req0_ready;
  logic [2:0]    req0_op;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [2:0]    req1_op;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_result;
  logic          busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_arbiter #(
  parameter int DW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  state_t        state;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] res_q;
  logic          id_q;
  logic          last_q;
  logic          idle;
  logic          gnt0;
  logic          gnt1;

  assign idle = (state == IDLE);

  // Requester 1 wins only alone, or in round-robin when 0 went last.
  assign gnt1 = bus.req1_valid &
                (~bus.req0_valid | (RR & ~last_q));
  assign gnt0 = bus.req0_valid & ~gnt1;

  assign bus.req0_ready = idle & gnt0;
  assign bus.req1_ready = idle & gnt1;

  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.busy       = ~idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            op_q  <= gnt1 ? bus.req1_op : bus.req0_op;
            a_q   <= gnt1 ? bus.req1_a  : bus.req0_a;
            b_q   <= gnt1 ? bus.req1_b  : bus.req0_b;
            id_q  <= gnt1;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q <= bus.alu_result;
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            last_q <= id_q;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: requester drivers, ALU model,
// response monitor and directed scenarios.
module tb_alu_arbiter;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

  typedef struct packed {
    logic       id;
    logic [3:0] res;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  req_t q0[$];
  req_t q1[$];
  rsp_t sb[$];
  int   gnt[$];

  alu_arbiter_if #(.DW(4)) bus ();

  alu_arbiter #(.DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Requesters: hold payload until accepted, then present the next one.
  initial begin
    logic a0;
    logic a1;
    req_t it;
    bus.req0_valid = 1'b0;
    bus.req0_op    = '0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_op    = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    forever begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else begin
        if (a0) bus.req0_valid = 1'b0;
        if (a1) bus.req1_valid = 1'b0;
        if (!bus.req0_valid && q0.size() > 0) begin
          it = q0.pop_front();
          bus.req0_op    = it.op;
          bus.req0_a     = it.a;
          bus.req0_b     = it.b;
          bus.req0_valid = 1'b1;
        end
        if (!bus.req1_valid && q1.size() > 0) begin
          it = q1.pop_front();
          bus.req1_op    = it.op;
          bus.req1_a     = it.a;
          bus.req1_b     = it.b;
          bus.req1_valid = 1'b1;
        end
      end
    end
  end

  // Monitor: push expectations on acceptance, pop on response.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n) begin
      if (bus.req0_ready || bus.req1_ready) begin
        chk("one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
        chk("ready_idle", {31'd0, bus.busy}, 0);
      end
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back({1'b0,
          alu_ref(bus.req0_op, bus.req0_a, bus.req0_b)});
        gnt.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back({1'b1,
          alu_ref(bus.req1_op, bus.req1_a, bus.req1_b)});
        gnt.push_back(1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
          chk("rsp_result", {28'd0, bus.rsp_result}, {28'd0, e.res});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_for(input int sel, input string tag);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = bus.req0_ready;
        1:       hit = bus.req1_ready;
        default: hit = bus.rsp_valid;
      endcase
    end
    chk(tag, {31'd0, hit}, 1);
  endtask

  task automatic drain(input string tag);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      done = q0.size() == 0 && q1.size() == 0 &&
             !bus.req0_valid && !bus.req1_valid &&
             sb.size() == 0 && !bus.busy;
    end
    chk(tag, {31'd0, done}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, bus.req0_ready}, 0);
    chk("rst_req1_ready", {31'd0, bus.req1_ready}, 0);
    chk("rst_alu_op", {29'd0, bus.alu_op}, 0);
    chk("rst_alu_a", {28'd0, bus.alu_a}, 0);
    chk("rst_alu_b", {28'd0, bus.alu_b}, 0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_rsp_id", {31'd0, bus.rsp_id}, 0);
    chk("rst_rsp_result", {28'd0, bus.rsp_result}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    tick();
    rst_n = 1'b1;

    // Single request: 3 + 4, response two cycles after acceptance.
    tick();
    q0.push_back('{op: 3'd0, a: 4'd3, b: 4'd4});
    wait_for(0, "t1_accept");
    @(negedge clk);
    chk("t1_busy", {31'd0, bus.busy}, 1);
    chk("t1_early_rsp", {31'd0, bus.rsp_valid}, 0);
    chk("t1_alu_op", {29'd0, bus.alu_op}, 0);
    chk("t1_alu_a", {28'd0, bus.alu_a}, 3);
    chk("t1_alu_b", {28'd0, bus.alu_b}, 4);
    @(negedge clk);
    chk("t1_rsp_valid", {31'd0, bus.rsp_valid}, 1);
    chk("t1_rsp_id", {31'd0, bus.rsp_id}, 0);
    chk("t1_rsp_result", {28'd0, bus.rsp_result}, 7);
    drain("t1_drain");

    // Backpressure: response must hold while the consumer stalls.
    tick();
    bus.rsp_ready = 1'b0;
    q1.push_back('{op: 3'd1, a: 4'd2, b: 4'd5});
    q1.push_back('{op: 3'd6, a: 4'd3, b: 4'd1});
    wait_for(2, "t3_rsp");
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", {31'd0, bus.rsp_valid}, 1);
      chk("t3_hold_id", {31'd0, bus.rsp_id}, 1);
      chk("t3_hold_result", {28'd0, bus.rsp_result}, 4'hd);
      chk("t3_hold_r0", {31'd0, bus.req0_ready}, 0);
      chk("t3_hold_r1", {31'd0, bus.req1_ready}, 0);
      chk("t3_hold_busy", {31'd0, bus.busy}, 1);
      @(negedge clk);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle_busy", {31'd0, bus.busy}, 0);
    chk("t3_idle_r1", {31'd0, bus.req1_ready}, 1);
    drain("t3_drain");

    // Contention with both requesters valid back to back.
    tick();
    gnt.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{op: 3'(i), a: 4'(i + 1), b: 4'(2 * i)});
      q1.push_back('{op: 3'(4 + i), a: 4'(9 + i), b: 4'(i)});
    end
    drain("t2_drain");
    chk("t2_count", gnt.size(), 8);
    if (gnt.size() >= 4) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("t2_g0", gnt[0], 0);
      chk("t2_g1", gnt[1], 0);
      chk("t2_g2", gnt[2], 0);
      chk("t2_g3", gnt[3], 0);
`else
      chk("t2_g0", gnt[0], 0);
      chk("t2_g1", gnt[1], 1);
      chk("t2_g2", gnt[2], 0);
      chk("t2_g3", gnt[3], 1);
`endif
    end

    // Payload changes after acceptance must not reach the ALU.
    tick();
    q1.push_back('{op: 3'd2, a: 4'hc, b: 4'ha});
    q1.push_back('{op: 3'd0, a: 4'h1, b: 4'h2});
    wait_for(1, "t4_accept");
    @(negedge clk);
    chk("t4_exec_alu_op", {29'd0, bus.alu_op}, 2);
    chk("t4_exec_alu_a", {28'd0, bus.alu_a}, 4'hc);
    chk("t4_exec_alu_b", {28'd0, bus.alu_b}, 4'ha);
    @(negedge clk);
    chk("t4_rsp_result", {28'd0, bus.rsp_result}, 4'h8);
    drain("t4_drain");

    // Reset while an operation is in EXEC.
    tick();
    q1.push_back('{op: 3'd3, a: 4'h5, b: 4'ha});
    wait_for(1, "t5_accept");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    q0.delete();
    q1.delete();
    gnt.delete();
    #1;
    chk("t5_rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("t5_rst_busy", {31'd0, bus.busy}, 0);
    chk("t5_rst_alu_a", {28'd0, bus.alu_a}, 0);
    chk("t5_rst_result", {28'd0, bus.rsp_result}, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_no_stale", {31'd0, bus.rsp_valid}, 0);
    chk("t5_idle", {31'd0, bus.busy}, 0);
    tick();
    q0.push_back('{op: 3'd0, a: 4'h1, b: 4'h1});
    q1.push_back('{op: 3'd4, a: 4'h2, b: 4'h7});
    drain("t5_drain");
    chk("t5_count", gnt.size(), 2);
    if (gnt.size() >= 2) begin
      chk("t5_first", gnt[0], 0);
      chk("t5_second", gnt[1], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
